// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
//
// Decode-to-execute immediate generator. Builds the sign/zero-extended
// immediate for the selected instruction format from decode-stage instruction
// bits. It then registers the immediate, the format select, the valid bit and
// an "unsupported format" flag into the execute stage.
//
// Parameters
//   XLEN      datapath width of the immediate (32 or 64)
//
// Ports
//   clk       clock, all state on the rising edge
//   rst       asynchronous active-high reset, clears every output register
//   instrD    instruction bits [31:7] from decode
//   immSelD   format select: 0 I, 1 U, 2 S, 3 B, 4 J, 5 L, 6 Z (CSR zimm), 7 SH
//   validD    decode instruction valid
//   stallE    hold the execute-stage register
//   flushE    clear the execute-stage register (wins over stallE)
//   immE      registered immediate
//   selE      registered format select
//   validE    registered valid
//   illegalE  registered flag: the select is not supported by this build
//
// Build option
//   IMM_GEN_ZIMM_EN  when defined, formats 6 (Z) and 7 (SH) are generated.
//                    When undefined, a valid load of format 6 or 7 produces
//                    immE=0 with illegalE=1.
// -----------------------------------------------------------------------------
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:7]     instrD,
  input  logic [2:0]      immSelD,
  input  logic            validD,
  input  logic            stallE,
  input  logic            flushE,
  output logic [XLEN-1:0] immE,
  output logic [2:0]      selE,
  output logic            validE,
  output logic            illegalE
);

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_U  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_J  = 3'd4,
    FMT_L  = 3'd5,
    FMT_Z  = 3'd6,
    FMT_SH = 3'd7
  } fmt_e;

  // Every signed format keeps bit 31 as the sign bit. The replication counts
  // are written so that none of them can be zero for XLEN=32.
  function automatic logic [XLEN-1:0] gen_imm(input logic [2:0] sel,
                                               input logic [31:7] ins);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (sel)
      FMT_I, FMT_L: imm = {{(XLEN-11){ins[31]}}, ins[30:20]};
      FMT_U:        imm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
      FMT_S:        imm = {{(XLEN-11){ins[31]}}, ins[30:25], ins[11:7]};
      FMT_B:        imm = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25],
                           ins[11:8], 1'b0};
      FMT_J:        imm = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20],
                           ins[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
      FMT_Z:        imm = {{(XLEN-5){1'b0}}, ins[19:15]};
      FMT_SH: begin
        // RV64 shift amounts carry one extra bit.
        if (XLEN == 64) imm = {{(XLEN-6){1'b0}}, ins[25:20]};
        else            imm = {{(XLEN-5){1'b0}}, ins[24:20]};
      end
`endif
      default:      imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic is_illegal(input logic [2:0] sel);
`ifdef IMM_GEN_ZIMM_EN
    is_illegal = 1'b0;
`else
    is_illegal = (sel == FMT_Z) || (sel == FMT_SH);
`endif
  endfunction

  logic [XLEN-1:0] imm_q, imm_d;
  logic [2:0]      sel_q, sel_d;
  logic            vld_q, vld_d;
  logic            ill_q, ill_d;

  // ---- decode -> execute boundary: next-state selection ----
  always_comb begin
    imm_d = imm_q;
    sel_d = sel_q;
    vld_d = vld_q;
    ill_d = ill_q;
    if (flushE) begin
      imm_d = '0;
      sel_d = '0;
      vld_d = 1'b0;
      ill_d = 1'b0;
    end else if (!stallE) begin
      if (validD) begin
        imm_d = gen_imm(immSelD, instrD);
        sel_d = immSelD;
        vld_d = 1'b1;
        ill_d = is_illegal(immSelD);
      end else begin
        // Bubble: drop valid/illegal but leave immE/selE untouched so the
        // data bus does not toggle.
        vld_d = 1'b0;
        ill_d = 1'b0;
      end
    end
  end

  // ---- execute-stage register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q <= '0;
      sel_q <= '0;
      vld_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      imm_q <= imm_d;
      sel_q <= sel_d;
      vld_q <= vld_d;
      ill_q <= ill_d;
    end
  end

  assign immE     = imm_q;
  assign selE     = sel_q;
  assign validE   = vld_q;
  assign illegalE = ill_q;

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the generated immediate; legal values 32 and 64.
REQ-002 Port clk  input  1  single clock, all state rising-edge triggered.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port instrD  input  25 (bits [31:7])  decode-stage instruction bits.
REQ-005 Port immSelD  input  3  format select: 0 I, 1 U, 2 S, 3 B, 4 J, 5 L(load), 6 Z(CSR zimm), 7 SH(shamt).
REQ-006 Port validD  input  1  decode-stage instruction valid.
REQ-007 Port stallE  input  1  hold execute-stage register.
REQ-008 Port flushE  input  1  kill execute-stage contents.
REQ-009 Port immE  output  XLEN  registered immediate for execute stage.
REQ-010 Port selE  output  3  registered copy of immSelD.
REQ-011 Port validE  output  1  registered valid.
REQ-012 Port illegalE  output  1  registered flag: select not supported by this build.

Function
REQ-013 Formats SHALL be: I/L = sext(instrD[31:20]); U = sext({instrD[31:12],12'b0}); S = sext({instrD[31:25],instrD[11:7]}); B = sext({instrD[31],instrD[7],instrD[30:25],instrD[11:8],1'b0}); J = sext({instrD[31],instrD[19:12],instrD[20],instrD[30:21],1'b0}).
REQ-014 All sign extension SHALL replicate instrD[31] up to bit XLEN-1 (U-type included for XLEN=64).
REQ-015 Z SHALL be zext(instrD[19:15]); SH SHALL be zext(instrD[24:20]) for XLEN=32, zext(instrD[25:20]) for XLEN=64.
REQ-016 Latency SHALL be exactly one clk edge from immSelD/instrD/validD to immE/selE/validE/illegalE.
REQ-017 Register update priority per edge SHALL be: flushE, then stallE, then normal load.
REQ-018 flushE=1 (regardless of stallE) SHALL load validE=0, illegalE=0, immE=0, selE=0.
REQ-019 stallE=1 with flushE=0 SHALL hold all four outputs unchanged, for any number of cycles.
REQ-020 Normal load with validD=1 SHALL capture the generated immediate, immSelD, validE=1, and the illegal flag.
REQ-021 Normal load with validD=0 SHALL set validE=0 and illegalE=0 and hold immE and selE (no toggling on bubbles).
REQ-022 Outputs SHALL be driven only from registers; no combinational path from inputs to outputs.

Reset
REQ-023 rst=1 SHALL immediately (without a clk edge) force immE=0, selE=0, validE=0, illegalE=0.
REQ-024 rst SHALL override stallE and flushE; the first edge after deassertion performs a normal REQ-017 update.

Configuration
REQ-025 Macro IMM_GEN_ZIMM_EN SHALL control formats 6 and 7.
REQ-026 With IMM_GEN_ZIMM_EN defined, selects 6/7 SHALL behave per REQ-015 and illegalE SHALL never assert.
REQ-027 Without IMM_GEN_ZIMM_EN, a valid load of select 6 or 7 SHALL give immE=0, illegalE=1, validE=1; selects 0-5 unaffected.

Verification
REQ-028 XLEN=32, validD=1, sel=0, instrD[31:20]=12'hFFF -> after one edge immE=32'hFFFFFFFF, validE=1, selE=0.
REQ-029 XLEN=32, sel=3, instrD[31]=1, all other bits 0 -> immE=32'hFFFFF000.
REQ-030 XLEN=64, sel=1, instrD[31:12]=20'h80000 -> immE=64'hFFFFFFFF80000000.
REQ-031 Load sel=2 imm 12'h7FF, then stallE=1 for 3 cycles with changing inputs -> immE stays 32'h000007FF; stallE=1 and flushE=1 together -> validE=0, immE=0.
REQ-032 sel=6, instrD[19:15]=5'h1F: with IMM_GEN_ZIMM_EN immE=32'h1F, illegalE=0; without it immE=0, illegalE=1, validE=1.
REQ-033 Assert rst mid-cycle while stallE=1 and validE=1 -> all outputs 0 before the next clk edge.
